// File: rtl/lab4_shared_reg_arbiter_pkg.sv
// Shared definitions for the round-robin shared-register arbiter.
package lab4_shared_reg_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Width of an index into n items, never narrower than one bit.
    function automatic int owner_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lab4_shared_reg_arbiter_dff.sv
// Single-bit positive-edge D flip-flop cell with true and complement outputs.
// Reset and load/hold selection live in the mux driving d.
module lab4_dff (
    input  logic clock,
    input  logic d,
    output logic q,
    output logic qb
);

    // Capture d on every rising edge.
    always_ff @(posedge clock) begin
        q <= d;
    end

    // Complement output tracks q combinationally.
    assign qb = ~q;

endmodule

// File: rtl/lab4_shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping from N-1 back to 0.
module lab4_rr_pick
    import lab4_shared_reg_arbiter_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = owner_w(N)
) (
    input  logic [N-1:0]  req_eff,
    input  logic [PW-1:0] pointer,
    output logic [PW-1:0] winner,
    output logic          any_req
);

    // Scan N positions starting at the pointer; the first hit wins.
    always_comb begin
        int idx;
        idx     = 0;
        winner  = '0;
        any_req = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = int'(pointer) + i;
            if (idx >= N) idx = idx - N;
            if (!any_req && req_eff[idx]) begin
                any_req = 1'b1;
                winner  = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/lab4_shared_reg_arbiter.sv
// Round-robin arbiter sharing one W-bit register among N requesters.
// A granted word is loaded, then frozen for HOLD_CYC cycles.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | arbitrate; on any effective request load winner's word
//   LOAD    | one cycle, grant visible; arms the hold down-counter
//   HOLD    | register/owner frozen, counter runs down to 0 then IDLE
module lab4_shared_reg_arbiter
    import lab4_shared_reg_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 4,
    parameter int HOLD_CYC = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N-1:0]          req,
    input  logic [N*W-1:0]        data_in,
    output logic [N-1:0]          grant,
    output logic [W-1:0]          Q,
    output logic [W-1:0]          Qb,
    output logic [owner_w(N)-1:0] owner,
    output logic                  busy
);

    localparam int OW = owner_w(N);
    localparam int CW = owner_w(HOLD_CYC);

    state_t        state;
    logic [CW-1:0] hold_cnt;
    logic [OW-1:0] rr_ptr;
    logic [OW-1:0] winner;
    logic          any_req;
    logic          load;
    logic [N-1:0]  req_eff;
    logic [W-1:0]  q_next;

    // A requester still seeing its grant cannot win again in the same breath.
    assign req_eff = req & ~grant;

    lab4_rr_pick #(.N(N)) u_pick (
        .req_eff (req_eff),
        .pointer (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    assign load = (state == ST_IDLE) && any_req;
    assign busy = (state != ST_IDLE);

    // Data mux ahead of the flop bank: reset clears, load takes winner, else hold.
    always_comb begin
        if (reset) begin
            q_next = '0;
        end else if (load) begin
            q_next = data_in[int'(winner)*W +: W];
        end else begin
            q_next = Q;
        end
    end

    for (genvar b = 0; b < W; b++) begin : g_bit
        lab4_dff u_dff (
            .clock (clock),
            .d     (q_next[b]),
            .q     (Q[b]),
            .qb    (Qb[b])
        );
    end

    // Sequencing FSM: grant, owner, pointer and hold timer are all registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            grant    <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant  <= N'(1) << winner;
                        owner  <= winner;
                        rr_ptr <= (int'(winner) == N - 1) ? '0 : winner + OW'(1);
                        state  <= ST_LOAD;
                    end else begin
                        grant <= '0;
                    end
                end
                ST_LOAD: begin
                    grant    <= '0;
                    hold_cnt <= CW'(HOLD_CYC - 1);
                    state    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule
